// File: rtl/ddr_tx.sv
// DDR transmitter: 16-bit words in on a valid/ready interface, buffered in a small FIFO,
// then sent as two bytes per clock (low byte in the high phase) framed by an active-low chip select.
module ddr_tx #(
  parameter int DW        = 8,
  parameter int DEPTH     = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [2*DW-1:0]          din,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic [DW-1:0]            dout,
  output logic                     dout_en,
  output logic                     tx_csn,
  output logic [$clog2(DEPTH):0]   fifo_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [7:0]    MAX_B    = 8'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t             state;
  logic [2*DW-1:0]    mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [7:0]         bcnt;
  logic               push;
  logic               pop;
  logic               fifo_empty;
  logic               can_pop;
  logic [DW-1:0]      lo_q;
  logic [DW-1:0]      hi_pend;
  logic [DW-1:0]      hi_q;

  assign din_ready  = (fifo_cnt != FULL_CNT);
  assign push       = din_valid && din_ready;
  assign fifo_empty = (fifo_cnt == '0);
  assign can_pop    = !fifo_empty && (bcnt < MAX_B);

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    pop = 1'b0;
    case (state)
      SETUP:      pop = 1'b1;
      XFER, HOLD: pop = can_pop;
      default:    pop = 1'b0;
    endcase
  end

  // NOTE: the storage array carries no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Frame sequencer; the chip select closes after MAX_BURST words or on underflow past HOLD.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      tx_csn  <= 1'b1;
      dout_en <= 1'b0;
      bcnt    <= '0;
    end else begin
      if (pop) bcnt <= bcnt + 8'd1;
      case (state)
        IDLE: begin
          bcnt    <= '0;
          dout_en <= 1'b0;
          if (!fifo_empty) begin
            state  <= SETUP;
            tx_csn <= 1'b0;
          end
        end
        SETUP: begin
          state   <= XFER;
          dout_en <= 1'b1;
        end
        XFER: begin
          if (can_pop) begin
            dout_en <= 1'b1;
          end else begin
            dout_en <= 1'b0;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (can_pop) begin
            dout_en <= 1'b1;
            state   <= XFER;
          end else begin
            state  <= IDLE;
            tx_csn <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          tx_csn  <= 1'b1;
          dout_en <= 1'b0;
        end
      endcase
    end
  end

  // Low byte launches on the rising edge; the high byte waits for the falling edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lo_q    <= '0;
      hi_pend <= '0;
    end else if (pop) begin
      lo_q    <= mem[rd_ptr][DW-1:0];
      hi_pend <= mem[rd_ptr][2*DW-1:DW];
    end
  end

  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      hi_q <= '0;
    end else if (dout_en) begin
      hi_q <= hi_pend;
    end
  end

  assign dout = clk ? lo_q : hi_q;

endmodule

// File: tb/tb_ddr_tx.sv
// Self-checking bench for ddr_tx: directed frame scenarios plus random traffic,
// compared every half cycle against a queue-based frame model.
module tb_ddr_tx;

  localparam int DW        = 8;
  localparam int DEPTH     = 4;
  localparam int MAX_BURST = 16;

  logic          clk;
  logic          rstn;
  logic [15:0]   din;
  logic          din_valid;
  logic          din_ready;
  logic [7:0]    dout;
  logic          dout_en;
  logic          tx_csn;
  logic [2:0]    fifo_cnt;

  ddr_tx #(.DW(DW), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .dout      (dout),
    .dout_en   (dout_en),
    .tx_csn    (tx_csn),
    .fifo_cnt  (fifo_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: buffered words, frame open flag, data-cycle flag, words sent this frame.
  logic [15:0] mq [$];
  logic [15:0] src [$];
  bit          m_csn;
  bit          m_en;
  bit          m_open;
  int          m_sent;
  int          m_dc;
  logic [7:0]  m_lo, m_hi, m_hpend;

  // Observations of the DUT per scenario.
  int          obs_data, obs_low, obs_frames, obs_blocked;
  bit          prev_csn;
  logic [7:0]  obs_lo, obs_hi;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_csn = 1'b1; m_en = 1'b0; m_open = 1'b0; m_sent = 0; m_dc = 0;
    m_lo = '0; m_hi = '0; m_hpend = '0;
  endtask

  task automatic obs_clear();
    obs_data = 0; obs_low = 0; obs_frames = 0; obs_blocked = 0; prev_csn = 1'b1;
    obs_lo = '0; obs_hi = '0;
  endtask

  task automatic model_edge(input bit v, input logic [15:0] d, output bit acc);
    int         pre;
    bit         can;
    bit         do_pop;
    logic [15:0] w;
    pre    = mq.size();
    can    = (pre > 0) && (m_sent < MAX_BURST);
    do_pop = 1'b0;
    if (m_csn) begin
      if (pre > 0) begin m_csn = 1'b0; m_open = 1'b1; m_sent = 0; end
    end else if (m_open) begin
      m_open = 1'b0; do_pop = 1'b1;
    end else if (m_en) begin
      if (can) do_pop = 1'b1; else m_en = 1'b0;
    end else begin
      if (can) do_pop = 1'b1; else m_csn = 1'b1;
    end
    if (do_pop) begin
      w = mq.pop_front();
      m_en = 1'b1; m_sent++; m_dc++;
      m_lo = w[7:0]; m_hpend = w[15:8];
    end
    acc = v && (pre < DEPTH);
    if (acc) mq.push_back(d);
  endtask

  // One clock: drive inputs, advance the model at the rising edge, check both phases.
  task automatic cycle(input bit v, input logic [15:0] d, output bit acc);
    din_valid = v;
    din       = d;
    if (v && !din_ready) obs_blocked++;
    @(posedge clk);
    model_edge(v, d, acc);
    #2;
    check("tx_csn",    tx_csn,    m_csn);
    check("dout_en",   dout_en,   m_en);
    check("fifo_cnt",  fifo_cnt,  mq.size());
    check("din_ready", din_ready, (mq.size() != DEPTH));
    check("dout_lo",   dout,      m_lo);
    if (dout_en) begin obs_data++; obs_lo = dout; end
    if (!tx_csn) obs_low++;
    if (prev_csn && !tx_csn) obs_frames++;
    prev_csn = tx_csn;
    @(negedge clk);
    if (m_en) m_hi = m_hpend;
    #2;
    check("dout_hi", dout, m_hi);
    if (dout_en) obs_hi = dout;
  endtask

  task automatic run_src();
    bit acc;
    for (int i = 0; i < 300 && src.size() > 0; i++) begin
      cycle(1'b1, src[0], acc);
      if (acc) void'(src.pop_front());
    end
    check("src_drained", src.size(), 0);
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 100 && !(m_csn && mq.size() == 0); i++) cycle(1'b0, 16'h0, acc);
    cycle(1'b0, 16'h0, acc);
    check("drain_idle", tx_csn, 1'b1);
  endtask

  initial begin
    bit acc;
    rstn = 1'b0; din = '0; din_valid = 1'b0;
    model_reset();
    obs_clear();
    repeat (2) @(negedge clk);
    #2;
    check("rst_csn",   tx_csn,    1'b1);
    check("rst_en",    dout_en,   1'b0);
    check("rst_dout",  dout,      8'h00);
    check("rst_cnt",   fifo_cnt,  3'd0);
    check("rst_ready", din_ready, 1'b1);
    rstn = 1'b1;

    // Single word into an idle block.
    obs_clear();
    src.push_back(16'hA55A);
    run_src();
    drain();
    check("single_data", obs_data, 1);
    check("single_low",  obs_low,  3);
    check("single_lo",   obs_lo,   8'h5A);
    check("single_hi",   obs_hi,   8'hA5);
    check("single_cnt",  fifo_cnt, 3'd0);

    // Eight-word stream, no bubbles.
    obs_clear();
    for (int i = 0; i < 8; i++) src.push_back(16'h0100 + 16'(i));
    run_src();
    drain();
    check("stream_data",   obs_data,   8);
    check("stream_frames", obs_frames, 1);
    check("stream_low",    obs_low,    10);
    check("stream_last",   {obs_hi, obs_lo}, 16'h0107);

    // Twenty words split by the burst limit.
    obs_clear();
    for (int i = 0; i < 20; i++) src.push_back(16'h2000 + 16'(i));
    run_src();
    drain();
    check("burst_data",   obs_data,   20);
    check("burst_frames", obs_frames, 2);

    // Fill while the output sits in the frame gap; the source must be held off.
    obs_clear();
    for (int i = 0; i < 21; i++) src.push_back(16'h3000 + 16'(i));
    run_src();
    drain();
    check("fill_blocked", (obs_blocked > 0), 1'b1);
    check("fill_data",    obs_data, 21);

    // Underflow inside a frame: one gap cycle, chip select stays low.
    obs_clear();
    cycle(1'b1, 16'h5001, acc);
    cycle(1'b1, 16'h5002, acc);
    cycle(1'b0, 16'h0000, acc);
    cycle(1'b0, 16'h0000, acc);
    cycle(1'b1, 16'h5003, acc);
    drain();
    check("uflow_data",   obs_data,   3);
    check("uflow_frames", obs_frames, 1);
    check("uflow_low",    obs_low,    6);

    // Asynchronous reset during the third data cycle of an eight-word burst.
    obs_clear();
    m_dc = 0;
    for (int i = 0; i < 8; i++) src.push_back(16'h0100 + 16'(i));
    for (int i = 0; i < 50 && m_dc < 3; i++) begin
      cycle(1'b1, src[0], acc);
      if (acc) void'(src.pop_front());
    end
    check("mid_reached", m_dc, 3);
    #1;
    rstn = 1'b0;
    din_valid = 1'b0;
    #1;
    check("mid_rst_csn",   tx_csn,    1'b1);
    check("mid_rst_en",    dout_en,   1'b0);
    check("mid_rst_dout",  dout,      8'h00);
    check("mid_rst_cnt",   fifo_cnt,  3'd0);
    check("mid_rst_ready", din_ready, 1'b1);
    src.delete();
    model_reset();
    @(posedge clk);
    #2;
    check("mid_rst_dout_hi_phase", dout, 8'h00);
    @(negedge clk);
    #2;
    rstn = 1'b1;
    obs_clear();
    src.push_back(16'h1234);
    run_src();
    drain();
    check("post_rst_data", obs_data, 1);
    check("post_rst_lo",   obs_lo,   8'h34);
    check("post_rst_hi",   obs_hi,   8'h12);

    // Random traffic against the model.
    obs_clear();
    for (int i = 0; i < 200; i++) begin
      cycle(1'($urandom_range(0, 1)), 16'($urandom), acc);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
